// File: rtl/fifo_arb_pkg.sv
// Shared helpers for the fifo round-robin read arbiter: ID width and modulo-N pointer math.
package fifo_arb_pkg;

    function automatic int unsigned idwid(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

    // Both operands must already be below n, so a single subtract wraps.
    function automatic int unsigned wrap_add(input int unsigned a, input int unsigned b,
                                             input int unsigned n);
        int unsigned s;
        s = a + b;
        return (s >= n) ? s - n : s;
    endfunction

    function automatic int unsigned wrap_inc(input int unsigned p, input int unsigned n);
        return (p == n - 1) ? 0 : p + 1;
    endfunction

endpackage

// File: rtl/fifo_rr_arbiter_rr_pick.sv
// Combinational round-robin pick: rotate requests to start at ptr, take the lowest, map back.
module rr_pick
    import fifo_arb_pkg::*;
#(
    parameter int unsigned N = 4,
    localparam int unsigned IDW = idwid(N)
) (
    input  logic [N-1:0]   req,
    input  logic [IDW-1:0] ptr,
    output logic [N-1:0]   gnt_onehot,
    output logic [IDW-1:0] gnt_idx,
    output logic           any
);

    logic [N-1:0]   rot;
    logic [IDW-1:0] hit_k;

    always_comb begin
        rot        = '0;
        hit_k      = '0;
        gnt_onehot = '0;
        gnt_idx    = '0;
        any        = |req;
        for (int k = 0; k < int'(N); k++) begin
            rot[k] = req[IDW'(wrap_add(32'(ptr), 32'(k), N))];
        end
        // Descending scan so the lowest rotated position wins.
        for (int k = int'(N) - 1; k >= 0; k--) begin
            if (rot[k]) begin
                hit_k = IDW'(k);
            end
        end
        gnt_idx = IDW'(wrap_add(32'(ptr), 32'(hit_k), N));
        if (any) begin
            gnt_onehot[gnt_idx] = 1'b1;
        end
    end

endmodule

// File: rtl/fifo_rr_arbiter.sv
// Round-robin read arbiter draining NUM_FIFOS fifos into one registered valid/ready stage.
module fifo_rr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int unsigned NUM_FIFOS = 4,
    parameter int unsigned WIDTH = 8,
    localparam int unsigned IDWID = idwid(NUM_FIFOS)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_FIFOS-1:0]       fifo_empty,
    input  logic [NUM_FIFOS*WIDTH-1:0] fifo_data,
    input  logic [NUM_FIFOS-1:0]       en_mask,
    output logic [NUM_FIFOS-1:0]       fifo_pop,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [WIDTH-1:0]           out_data,
    output logic [IDWID-1:0]           out_id
);

    logic [IDWID-1:0]     rr_ptr;
    logic [NUM_FIFOS-1:0] req;
    logic [NUM_FIFOS-1:0] gnt_onehot;
    logic [IDWID-1:0]     gnt_idx;
    logic                 any_req;
    logic                 load_c;
    logic [WIDTH-1:0]     data_arr [NUM_FIFOS];

    always_comb begin
        for (int i = 0; i < int'(NUM_FIFOS); i++) begin
            data_arr[i] = fifo_data[i*WIDTH +: WIDTH];
        end
    end

    assign req = ~fifo_empty & en_mask;

    rr_pick #(
        .N(NUM_FIFOS)
    ) u_pick (
        .req        (req),
        .ptr        (rr_ptr),
        .gnt_onehot (gnt_onehot),
        .gnt_idx    (gnt_idx),
        .any        (any_req)
    );

    // A drain and refill in the same cycle counts as a load.
    assign load_c   = !rst && any_req && (!out_valid || out_ready);
    assign fifo_pop = load_c ? gnt_onehot : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr    <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_id    <= '0;
        end else if (load_c) begin
            out_data  <= data_arr[gnt_idx];
            out_id    <= gnt_idx;
            out_valid <= 1'b1;
            rr_ptr    <= IDWID'(wrap_inc(32'(gnt_idx), NUM_FIFOS));
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

`ifdef FORMAL
    a_pop_onehot0: assert property (@(posedge clk) $onehot0(fifo_pop));
    a_pop_nonempty: assert property (@(posedge clk) (fifo_pop & fifo_empty) == '0);
    a_hold_stable: assert property (@(posedge clk) disable iff (rst)
        (out_valid && !out_ready) |=> ($stable(out_data) && $stable(out_id)));
`endif

endmodule

// File: tb/tb_fifo_rr_arbiter.sv
// Directed bench for fifo_rr_arbiter: per-cycle vector table plus hand-written multi-cycle sequences.
module tb_fifo_rr_arbiter;

    localparam int unsigned N = 4;
    localparam int unsigned W = 8;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   fifo_empty;
    logic [N*W-1:0] fifo_data;
    logic [N-1:0]   en_mask;
    logic [N-1:0]   fifo_pop;
    logic           out_valid;
    logic           out_ready;
    logic [W-1:0]   out_data;
    logic [1:0]     out_id;

    logic           use_model;
    logic [N-1:0]   tb_empty;
    logic [W-1:0]   tb_dat [N];
    int             cap [N];
    int             popped [N] = '{0, 0, 0, 0};

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fifo_rr_arbiter #(.NUM_FIFOS(N), .WIDTH(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .fifo_empty (fifo_empty),
        .fifo_data  (fifo_data),
        .en_mask    (en_mask),
        .fifo_pop   (fifo_pop),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_id     (out_id)
    );

    // Fifo model: a fifo is empty once its pop count reaches its capacity mark.
    always_comb begin
        for (int i = 0; i < int'(N); i++) begin
            fifo_empty[i] = use_model ? (popped[i] >= cap[i]) : tb_empty[i];
            fifo_data[i*W +: W] = tb_dat[i];
        end
    end

    always @(posedge clk) begin
        for (int i = 0; i < int'(N); i++) begin
            if (fifo_pop[i]) popped[i] <= popped[i] + 1;
        end
    end

    typedef struct {
        logic         rst;
        logic [N-1:0] empty;
        logic [N-1:0] mask;
        logic         rdy;
        logic [N-1:0] e_pop;
        logic         e_valid;
        logic [W-1:0] e_data;
        logic [1:0]   e_id;
    } vec_t;

    vec_t tbl [18];

    function automatic vec_t v(input logic r, input logic [3:0] em, input logic [3:0] mk,
                               input logic rd, input logic [3:0] ep, input logic ev,
                               input logic [7:0] ed, input logic [1:0] ei);
        vec_t x;
        x.rst = r; x.empty = em; x.mask = mk; x.rdy = rd;
        x.e_pop = ep; x.e_valid = ev; x.e_data = ed; x.e_id = ei;
        return x;
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    task automatic reset_dut();
        @(negedge clk);
        rst = 1'b1;
    endtask

    int exp_seq [10] = '{0, 1, 3, 0, 1, 3, 1, 3, 1, 3};
    int snap;

    initial begin
        rst = 1'b1; use_model = 1'b0; tb_empty = '0; en_mask = '1; out_ready = 1'b1;
        for (int i = 0; i < int'(N); i++) begin
            tb_dat[i] = 8'h10 + 8'(i);
            cap[i] = 0;
        end

        // Each row: inputs for this cycle, expected pop now and register state from the previous edge.
        tbl[0]  = v(1, 4'b0000, 4'b1111, 1, 4'b0000, 0, 8'h00, 2'd0);
        tbl[1]  = v(1, 4'b0000, 4'b1111, 1, 4'b0000, 0, 8'h00, 2'd0);
        tbl[2]  = v(0, 4'b0000, 4'b1111, 1, 4'b0001, 0, 8'h00, 2'd0);
        tbl[3]  = v(0, 4'b0000, 4'b1111, 1, 4'b0010, 1, 8'h10, 2'd0);
        tbl[4]  = v(0, 4'b0000, 4'b1111, 1, 4'b0100, 1, 8'h11, 2'd1);
        tbl[5]  = v(0, 4'b0000, 4'b1111, 1, 4'b1000, 1, 8'h12, 2'd2);
        tbl[6]  = v(0, 4'b0000, 4'b1111, 1, 4'b0001, 1, 8'h13, 2'd3);
        tbl[7]  = v(0, 4'b1101, 4'b1111, 1, 4'b0010, 1, 8'h10, 2'd0);
        tbl[8]  = v(0, 4'b0101, 4'b1111, 1, 4'b1000, 1, 8'h11, 2'd1);
        tbl[9]  = v(0, 4'b0101, 4'b1111, 1, 4'b0010, 1, 8'h13, 2'd3);
        tbl[10] = v(0, 4'b0101, 4'b1111, 1, 4'b1000, 1, 8'h11, 2'd1);
        tbl[11] = v(0, 4'b0101, 4'b1111, 1, 4'b0010, 1, 8'h13, 2'd3);
        tbl[12] = v(0, 4'b1111, 4'b1111, 1, 4'b0000, 1, 8'h11, 2'd1);
        tbl[13] = v(0, 4'b1111, 4'b1111, 1, 4'b0000, 0, 8'h11, 2'd1);
        tbl[14] = v(0, 4'b0000, 4'b0000, 1, 4'b0000, 0, 8'h11, 2'd1);
        tbl[15] = v(0, 4'b0000, 4'b0001, 1, 4'b0001, 0, 8'h11, 2'd1);
        tbl[16] = v(0, 4'b0000, 4'b1111, 0, 4'b0000, 1, 8'h10, 2'd0);
        tbl[17] = v(0, 4'b0000, 4'b1111, 1, 4'b0010, 1, 8'h10, 2'd0);

        reset_dut();
        for (int r = 0; r < 18; r++) begin
            @(negedge clk);
            rst = tbl[r].rst; tb_empty = tbl[r].empty;
            en_mask = tbl[r].mask; out_ready = tbl[r].rdy;
            #1;
            check($sformatf("tbl%0d_pop", r), 32'(fifo_pop), 32'(tbl[r].e_pop));
            check($sformatf("tbl%0d_valid", r), 32'(out_valid), 32'(tbl[r].e_valid));
            check($sformatf("tbl%0d_data", r), 32'(out_data), 32'(tbl[r].e_data));
            check($sformatf("tbl%0d_id", r), 32'(out_id), 32'(tbl[r].e_id));
        end

        // Backpressure: A5 from fifo 2 held while out_ready is low, then fifo 3 is next.
        use_model = 1'b1;
        reset_dut();
        out_ready = 1'b0; en_mask = '1;
        cap[0] = popped[0]; cap[1] = popped[1];
        cap[2] = popped[2] + 3; cap[3] = popped[3] + 3;
        tb_dat[2] = 8'hA5; tb_dat[3] = 8'h33;
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("bp_first_pop", 32'(fifo_pop), 32'(4'b0100));
        check("bp_first_valid", 32'(out_valid), 32'd0);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            #1;
            check($sformatf("bp_hold%0d_pop", c), 32'(fifo_pop), 32'd0);
            check($sformatf("bp_hold%0d_data", c), 32'(out_data), 32'hA5);
            check($sformatf("bp_hold%0d_id", c), 32'(out_id), 32'd2);
            check($sformatf("bp_hold%0d_valid", c), 32'(out_valid), 32'd1);
        end
        @(negedge clk);
        out_ready = 1'b1;
        #1;
        check("bp_release_pop", 32'(fifo_pop), 32'(4'b1000));
        check("bp_release_data", 32'(out_data), 32'hA5);
        @(negedge clk);
        #1;
        check("bp_next_data", 32'(out_data), 32'h33);
        check("bp_next_id", 32'(out_id), 32'd3);
        check("bp_next_pop", 32'(fifo_pop), 32'(4'b0100));

        // Mask 1011 with fifo 0 holding only two words.
        reset_dut();
        out_ready = 1'b1; en_mask = 4'b1011;
        for (int i = 0; i < int'(N); i++) begin
            tb_dat[i] = 8'h10 + 8'(i);
            cap[i] = popped[i] + 20;
        end
        cap[0] = popped[0] + 2;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            rst = 1'b0;
            #1;
            check($sformatf("mask%0d_pop", k), 32'(fifo_pop), 32'(4'b0001 << exp_seq[k]));
            check($sformatf("mask%0d_pop_empty", k), 32'(fifo_pop & fifo_empty), 32'd0);
            if (k > 0) begin
                check($sformatf("mask%0d_id", k), 32'(out_id), 32'(exp_seq[k-1]));
                check($sformatf("mask%0d_data", k), 32'(out_data), 32'(8'h10 + 8'(exp_seq[k-1])));
            end
        end

        // Reset while a word is held under backpressure.
        reset_dut();
        out_ready = 1'b1; en_mask = '1;
        for (int i = 0; i < int'(N); i++) cap[i] = popped[i] + 5;
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("mid_pop0", 32'(fifo_pop), 32'(4'b0001));
        @(negedge clk);
        #1;
        check("mid_pop1", 32'(fifo_pop), 32'(4'b0010));
        @(negedge clk);
        out_ready = 1'b0;
        #1;
        check("mid_stall_pop", 32'(fifo_pop), 32'd0);
        check("mid_stall_valid", 32'(out_valid), 32'd1);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("mid_rst_pop", 32'(fifo_pop), 32'd0);
        snap = popped[0] + popped[1] + popped[2] + popped[3];
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("mid_after_valid", 32'(out_valid), 32'd0);
        check("mid_after_ptr_pop", 32'(fifo_pop), 32'(4'b0001));
        check("mid_no_loss", 32'(popped[0] + popped[1] + popped[2] + popped[3]), 32'(snap));
        @(negedge clk);
        #1;
        check("mid_reload_id", 32'(out_id), 32'd0);
        check("mid_reload_data", 32'(out_data), 32'h10);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
